// File: rtl/led_pattern_gen_if.sv
// Pin-side bundle of led_pattern_gen: button in, LED drive, mode and step pulse out.
// LED_PATTERN_GEN_PWM_DIM_EN adds the 4-bit dim input.
interface led_pattern_gen_if #(
  parameter int LED_N = 8
);
  logic             btnx;
  logic [LED_N-1:0] ledx;
  logic [1:0]       mode;
  logic             tick;
`ifdef LED_PATTERN_GEN_PWM_DIM_EN
  logic [3:0]       dim;

  modport master (input btnx, dim, output ledx, mode, tick);
  modport slave  (output btnx, dim, input ledx, mode, tick);
`else
  modport master (input btnx, output ledx, mode, tick);
  modport slave  (output btnx, input ledx, mode, tick);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// Four-pattern LED driver (count/scan/blink/gray) with a debounced mode button.
// Optional LED_PATTERN_GEN_PWM_DIM_EN gates the lit LEDs with a 16-step PWM duty.
module led_pattern_gen #(
  parameter int CLK_HZ     = 24_000_000,
  parameter int STEP_HZ    = 1,
  parameter int LED_N      = 8,
  parameter int DEB_CYCLES = 240_000
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_gen_if.master bus
);
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DW  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {COUNT = 2'd0, SCAN = 2'd1, BLINK = 2'd2, GRAY = 2'd3} mode_t;

  mode_t            mode_q, mode_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic [LED_N-1:0] cnt, cnt_nx, pos, pos_nx, pat, ledx_q;
  logic             dir, dir_nx, blink, blink_nx;
  logic             s1, s2, stable, press, tick_w, lit;
  logic [DW-1:0]    deb_cnt;

  assign tick_w = (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus.btnx;
      s2 <= s1;
    end

  // Any return to the stable level restarts the stability window, so short glitches vanish.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stable  <= 1'b1;
      deb_cnt <= '0;
    end else if (s2 == stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      stable  <= s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end

  assign press = (s2 != stable) && (deb_cnt == DEB_LAST) && !s2;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= COUNT;
      presc  <= '0;
      cnt    <= '0;
      pos    <= LED_N'(1);
      dir    <= 1'b0;
      blink  <= 1'b0;
    end else begin
      mode_q <= mode_nx;
      presc  <= presc_nx;
      cnt    <= cnt_nx;
      pos    <= pos_nx;
      dir    <= dir_nx;
      blink  <= blink_nx;
    end

  always_comb begin
    mode_nx  = mode_q;
    presc_nx = tick_w ? '0 : presc + 1'b1;
    cnt_nx   = cnt;
    pos_nx   = pos;
    dir_nx   = dir;
    blink_nx = blink;
    // A press restarts the pattern and the step timer; a coincident tick is dropped.
    if (press) begin
      mode_nx  = mode_t'(mode_q + 2'd1);
      presc_nx = '0;
      cnt_nx   = '0;
      pos_nx   = LED_N'(1);
      dir_nx   = 1'b0;
      blink_nx = 1'b0;
    end else if (tick_w) begin
      case (mode_q)
        COUNT, GRAY: cnt_nx = cnt + 1'b1;
        SCAN: begin
          if (!dir) begin
            if (pos[LED_N-1]) begin
              pos_nx = pos >> 1;
              dir_nx = 1'b1;
            end else begin
              pos_nx = pos << 1;
            end
          end else if (pos[0]) begin
            pos_nx = pos << 1;
            dir_nx = 1'b0;
          end else begin
            pos_nx = pos >> 1;
          end
        end
        default: blink_nx = ~blink;
      endcase
    end
  end

  always_comb begin
    pat = cnt;
    case (mode_q)
      COUNT:   pat = cnt;
      SCAN:    pat = pos;
      BLINK:   pat = {LED_N{blink}};
      default: pat = cnt ^ (cnt >> 1);
    endcase
  end

`ifdef LED_PATTERN_GEN_PWM_DIM_EN
  logic [3:0] pwm;

  always_ff @(posedge clk or posedge rst)
    if (rst) pwm <= '0;
    else     pwm <= pwm + 4'd1;

  assign lit = (pwm < bus.dim);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) ledx_q <= '1;
    else     ledx_q <= ~(pat & {LED_N{lit}});

  assign bus.ledx = ledx_q;
  assign bus.mode = mode_q;
  assign bus.tick = tick_w;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed table, randomized button activity against a
// step-count reference model, reset and tick-timing sequences.
module tb_led_pattern_gen;
  localparam int CLK_HZ = 1000, STEP_HZ = 100, LED_N = 8, DEB = 16;
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int SCAN_PER = 2 * (LED_N - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_pattern_gen_if #(.LED_N(LED_N)) bus ();

  led_pattern_gen #(
    .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .LED_N(LED_N), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pattern derived from mode and number of steps taken in that mode.
  bit         m_s1, m_s2, m_stable;
  int         m_run, m_mode, m_steps, m_phase, m_pwm;
  logic [7:0] m_led;

  function automatic logic [7:0] pat_of(input int md, input int st);
    int k, g;
    case (md)
      0: return 8'(st % 256);
      1: begin
        k = st % SCAN_PER;
        return (k <= LED_N - 1) ? 8'(1 << k) : 8'(1 << (SCAN_PER - k));
      end
      2: return (st % 2 == 1) ? 8'hFF : 8'h00;
      default: begin
        g = st % 256;
        return 8'(g ^ (g >> 1));
      end
    endcase
  endfunction

  task automatic m_reset();
    m_s1 = 1; m_s2 = 1; m_stable = 1; m_run = 0;
    m_mode = 0; m_steps = 0; m_phase = 0; m_pwm = 0; m_led = 8'hFF;
  endtask

  task automatic m_edge();
    logic [7:0] p;
    bit gate, press;
    p = pat_of(m_mode, m_steps);
`ifdef LED_PATTERN_GEN_PWM_DIM_EN
    gate = (m_pwm < int'(bus.dim));
`else
    gate = 1;
`endif
    m_led = gate ? ~p : 8'hFF;
    press = 0;
    if (m_s2 != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = m_s2;
        press = (m_s2 == 0);
        m_run = 0;
      end
    end else m_run = 0;
    if (press) begin
      m_mode = (m_mode + 1) % 4;
      m_steps = 0;
      m_phase = 0;
    end else begin
      if (m_phase == DIV - 1) m_steps++;
      m_phase = (m_phase + 1) % DIV;
    end
    m_s2 = m_s1;
    m_s1 = bus.btnx;
    m_pwm = (m_pwm + 1) % 16;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      m_edge();
      @(negedge clk);
      chk("model_ledx", 32'(bus.ledx), 32'(m_led));
      chk("model_mode", 32'(bus.mode), 32'(m_mode));
      chk("model_tick", 32'(bus.tick), 32'(m_phase == DIV - 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ledx", 32'(bus.ledx), 32'hFF);
    chk("rst_mode", 32'(bus.mode), 32'h0);
    chk("rst_tick", 32'(bus.tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       btn;
    int         cycles;
    logic [1:0] mode;
    logic [7:0] led;
  } vec_t;

  vec_t vecs[16];
  int   n;

  initial begin
    vecs[0]  = '{1'b1, 31,   2'd0, 8'hFC};  // three COUNT steps
    vecs[1]  = '{1'b1, 2530, 2'd0, 8'hFF};  // 256 steps wraps to zero
    vecs[2]  = '{1'b0, 19,   2'd1, 8'hFE};  // press seen 18 clks after fall
    vecs[3]  = '{1'b0, 21,   2'd1, 8'hFB};
    vecs[4]  = '{1'b1, 100,  2'd1, 8'hFB};  // release: no mode change
    vecs[5]  = '{1'b0, 10,   2'd1, 8'hFD};  // short glitch ignored
    vecs[6]  = '{1'b1, 30,   2'd1, 8'hFB};
    vecs[7]  = '{1'b0, 18,   2'd2, 8'hF7};  // press coincides with tick
    vecs[8]  = '{1'b0, 1,    2'd2, 8'hFF};
    vecs[9]  = '{1'b0, 10,   2'd2, 8'h00};
    vecs[10] = '{1'b1, 40,   2'd2, 8'h00};
    vecs[11] = '{1'b0, 18,   2'd3, 8'hFF};
    vecs[12] = '{1'b0, 1,    2'd3, 8'hFF};
    vecs[13] = '{1'b1, 21,   2'd3, 8'hFC};  // gray after 2 steps
    vecs[14] = '{1'b1, 10,   2'd3, 8'hFD};  // gray after 3 steps
    vecs[15] = '{1'b0, 18,   2'd0, 8'hF9};  // GRAY -> COUNT

    bus.btnx = 1'b1;
`ifdef LED_PATTERN_GEN_PWM_DIM_EN
    bus.dim = 4'd15;
`endif
    m_reset();
    do_reset();

    foreach (vecs[i]) begin
      bus.btnx = vecs[i].btn;
      cyc(vecs[i].cycles);
      chk($sformatf("vec%0d_mode", i), 32'(bus.mode), 32'(vecs[i].mode));
`ifndef LED_PATTERN_GEN_PWM_DIM_EN
      chk($sformatf("vec%0d_ledx", i), 32'(bus.ledx), 32'(vecs[i].led));
`endif
    end
    bus.btnx = 1'b1;
    cyc(1);
`ifndef LED_PATTERN_GEN_PWM_DIM_EN
    chk("count_restart_ledx", 32'(bus.ledx), 32'hFF);
`endif

    // Random button activity, including sub-debounce glitches and long holds.
    for (int i = 0; i < 60; i++) begin
      bus.btnx = 1'($urandom_range(0, 1));
      cyc((i % 3 == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 20)));
    end
    bus.btnx = 1'b1;
    cyc(40);

    // Reset mid-COUNT at cnt=0x5A acts before any clock edge.
    do_reset();
`ifdef LED_PATTERN_GEN_PWM_DIM_EN
    bus.dim = 4'd0;
`endif
    cyc(901);
`ifndef LED_PATTERN_GEN_PWM_DIM_EN
    chk("cnt5a_ledx", 32'(bus.ledx), 32'hA5);
`endif
    #2 rst = 1'b1;
    #1;
    chk("midrst_ledx", 32'(bus.ledx), 32'hFF);
    chk("midrst_mode", 32'(bus.mode), 32'h0);
    chk("midrst_tick", 32'(bus.tick), 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    n = 1;
    while (!bus.tick && n < 20) begin
      cyc(1);
      n++;
    end
    chk("first_tick_cycle", 32'(n), 32'd10);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!bus.tick && n < 20);
    chk("tick_period", 32'(n), 32'd10);

`ifdef LED_PATTERN_GEN_PWM_DIM_EN
    do_reset();
    bus.dim = 4'd4;
    cyc(2551);
    for (int i = 0; i < 40; i++) begin
      bus.dim = 4'($urandom_range(0, 15));
      cyc(int'($urandom_range(1, 20)));
    end
    bus.dim = 4'd0;
    cyc(2);
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      chk("dim0_ledx", 32'(bus.ledx), 32'hFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
